// File: rtl/axis_dac_scheduler.sv
// axis_dac_scheduler: paced merge of two AXI-Stream DAC channels into one 32-bit word stream.
// Define AXIS_DAC_SCHED_UNDERRUN_CNT_EN to build the saturating underrun counter.
module axis_dac_scheduler #(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cfg_enable,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic                 cfg_underrun_zero,
  input  logic [15:0]          s_axis_a_tdata,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [15:0]          s_axis_b_tdata,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 sts_running,
  output logic                 sts_underrun,
  output logic [15:0]          sts_underrun_count
);
  localparam int W = DAC_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;
  state_t state;
  logic [W-1:0] hold_a, hold_b, last_a, last_b, val_a, val_b;
  logic full_a, full_b, tick, hs_a, hs_b, under;
  logic [DIV_WIDTH-1:0] cnt;
  logic unused_hi;
  function automatic logic [15:0] sx(input logic [W-1:0] v);
    return 16'($signed(v));
  endfunction
  assign unused_hi = ^{s_axis_a_tdata[15:W], s_axis_b_tdata[15:W]};
  assign tick = state == RUN && cnt == '0;
  assign s_axis_a_tready = (state == PRIME && !full_a) || (state == RUN && (!full_a || tick));
  assign s_axis_b_tready = (state == PRIME && !full_b) || (state == RUN && (!full_b || tick));
  assign hs_a = s_axis_a_tvalid && s_axis_a_tready;
  assign hs_b = s_axis_b_tvalid && s_axis_b_tready;
  assign val_a = full_a ? hold_a : cfg_underrun_zero ? '0 : last_a;
  assign val_b = full_b ? hold_b : cfg_underrun_zero ? '0 : last_b;
  assign under = tick && cfg_enable && !(full_a && full_b);
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      hold_a <= '0;
      hold_b <= '0;
      last_a <= '0;
      last_b <= '0;
      full_a <= 1'b0;
      full_b <= 1'b0;
      cnt <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      sts_running <= 1'b0;
      sts_underrun <= 1'b0;
    end else begin
      if (hs_a) hold_a <= s_axis_a_tdata[W-1:0];
      if (hs_b) hold_b <= s_axis_b_tdata[W-1:0];
      // a tick consumes the registers; a same-cycle handshake refills them
      full_a <= hs_a || (full_a && !tick);
      full_b <= hs_b || (full_b && !tick);
      case (state)
        IDLE: if (cfg_enable) begin
          state <= PRIME;
          full_a <= 1'b0;
          full_b <= 1'b0;
          sts_underrun <= 1'b0;
          sts_running <= 1'b1;
        end
        PRIME: if (!cfg_enable) begin
          state <= IDLE;
          sts_running <= 1'b0;
        end else if (full_a && full_b) begin
          state <= RUN;
          cnt <= '0;
        end
        RUN: if (!cfg_enable) begin
          state <= STOP;
          m_axis_tdata <= '0;
          m_axis_tvalid <= 1'b1;
        end else if (tick) begin
          m_axis_tdata <= {sx(val_b), sx(val_a)};
          m_axis_tvalid <= 1'b1;
          last_a <= val_a;
          last_b <= val_b;
          cnt <= cfg_divider;
          if (under) sts_underrun <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
          if (m_axis_tready) m_axis_tvalid <= 1'b0;
        end
        STOP: if (m_axis_tready) begin
          state <= IDLE;
          m_axis_tvalid <= 1'b0;
          sts_running <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXIS_DAC_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) sts_underrun_count <= '0;
    else if (state == IDLE && cfg_enable) sts_underrun_count <= '0;
    else if (under && sts_underrun_count != 16'hFFFF) sts_underrun_count <= sts_underrun_count + 1'b1;
  end
`else
  assign sts_underrun_count = '0;
`endif
endmodule

// File: tb/tb_axis_dac_scheduler.sv
// tb_axis_dac_scheduler: directed checks of pacing, underrun substitution, backpressure, stop and reset.
module tb_axis_dac_scheduler;
`ifdef AXIS_DAC_SCHED_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic aclk = 1'b0, areset, cfg_enable, cfg_underrun_zero;
  logic [15:0] cfg_divider, a_data, b_data, ucnt;
  logic a_valid, a_ready, b_valid, b_ready, m_valid, m_ready, running, underrun;
  logic [31:0] m_data;
  int a_idx, b_idx, b_lim, vectors = 0, errors = 0;
  always #5 aclk = ~aclk;
  axis_dac_scheduler dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_divider(cfg_divider),
    .cfg_underrun_zero(cfg_underrun_zero),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_ready),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .sts_running(running), .sts_underrun(underrun), .sts_underrun_count(ucnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    a_data = 16'h2000 + 16'(a_idx);
    a_valid = 1'b1;
    b_data = 16'hC100 + 16'(b_idx);
    b_valid = b_idx < b_lim;
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      logic ha, hb;
      ha = a_valid && a_ready;
      hb = b_valid && b_ready;
      @(posedge aclk);
      #1;
      if (ha) a_idx++;
      if (hb) b_idx++;
      drive();
    end
  endtask
  task automatic start(input logic [15:0] div, input logic uz, input int blim);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    a_idx = 0;
    b_idx = 0;
    b_lim = blim;
    cfg_divider = div;
    cfg_underrun_zero = uz;
    m_ready = 1'b1;
    cfg_enable = 1'b1;
    drive();
  endtask
  initial begin
    areset = 1'b1;
    cfg_enable = 1'b0;
    cfg_divider = 16'd3;
    cfg_underrun_zero = 1'b0;
    m_ready = 1'b1;
    a_idx = 0;
    b_idx = 0;
    b_lim = 1000;
    drive();
    #2;
    chk("rst_tvalid", 32'(m_valid), 32'd0);
    chk("rst_tdata", m_data, 32'h0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", 32'(ucnt), 32'd0);
    // prime and pace, divider 3
    start(16'd3, 1'b0, 1000);
    cyc(2);
    chk("prime_full_ready", 32'({a_ready, b_ready}), 32'd0);
    cyc(2);
    chk("pace_w0_valid", 32'(m_valid), 32'd1);
    chk("pace_w0_data", m_data, 32'h0100E000);
    chk("pace_running", 32'(running), 32'd1);
    cyc(1);
    chk("pace_gap", 32'(m_valid), 32'd0);
    cyc(3);
    chk("pace_w1_valid", 32'(m_valid), 32'd1);
    chk("pace_w1_data", m_data, 32'h0101E001);
    chk("pace_no_underrun", 32'(underrun), 32'd0);
    // underrun, hold mode
    start(16'd3, 1'b0, 2);
    cyc(8);
    chk("hold_w1", m_data, 32'h0101E001);
    chk("hold_pre_flag", 32'(underrun), 32'd0);
    cyc(4);
    chk("hold_w2", m_data, 32'h0101E002);
    chk("hold_flag", 32'(underrun), 32'd1);
    chk("hold_cnt1", 32'(ucnt), CNT_EN ? 32'd1 : 32'd0);
    cyc(4);
    chk("hold_w3", m_data, 32'h0101E003);
    chk("hold_cnt2", 32'(ucnt), CNT_EN ? 32'd2 : 32'd0);
    // underrun, zero mode
    start(16'd3, 1'b1, 2);
    cyc(12);
    chk("zero_w2", m_data, 32'h0000E002);
    chk("zero_flag", 32'(underrun), 32'd1);
    cyc(4);
    chk("zero_w3", m_data, 32'h0000E003);
    chk("zero_cnt2", 32'(ucnt), CNT_EN ? 32'd2 : 32'd0);
    // back-to-back, divider 0
    start(16'd0, 1'b0, 1000);
    cyc(4);
    for (int k = 0; k < 6; k++) begin
      chk("b2b_valid", 32'(m_valid), 32'd1);
      chk("b2b_data", m_data, {16'h0100 + 16'(k), 16'hE000 + 16'(k)});
      cyc(1);
    end
    chk("b2b_no_underrun", 32'(underrun), 32'd0);
    // backpressure overwrite, divider 1
    start(16'd1, 1'b0, 1000);
    m_ready = 1'b0;
    cyc(4);
    chk("bp_w0", m_data, 32'h0100E000);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("bp_held_valid", 32'(m_valid), 32'd1);
    end
    chk("bp_latest", m_data, 32'h0102E002);
    cyc(1);
    m_ready = 1'b1;
    chk("bp_release_data", m_data, 32'h0102E002);
    chk("bp_release_valid", 32'(m_valid), 32'd1);
    cyc(1);
    chk("bp_next_data", m_data, 32'h0103E003);
    cyc(1);
    chk("bp_drained", 32'(m_valid), 32'd0);
    // stop sequence with a pending word
    start(16'd3, 1'b0, 1000);
    m_ready = 1'b0;
    cyc(4);
    chk("stop_pending", m_data, 32'h0100E000);
    cyc(1);
    cfg_enable = 1'b0;
    cyc(1);
    chk("stop_zero", m_data, 32'h0);
    chk("stop_valid", 32'(m_valid), 32'd1);
    chk("stop_ready_low", 32'({a_ready, b_ready}), 32'd0);
    cyc(1);
    cfg_enable = 1'b1;
    chk("stop_hold_zero", m_data, 32'h0);
    cyc(1);
    chk("stop_ignore_en", 32'(m_valid), 32'd1);
    chk("stop_running", 32'(running), 32'd1);
    m_ready = 1'b1;
    cyc(1);
    cfg_enable = 1'b0;
    chk("stop_idle_valid", 32'(m_valid), 32'd0);
    chk("stop_idle_running", 32'(running), 32'd0);
    // asynchronous reset mid-run
    start(16'd3, 1'b0, 2);
    cyc(12);
    chk("ar_pre_valid", 32'(m_valid), 32'd1);
    chk("ar_pre_flag", 32'(underrun), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_data", m_data, 32'h0);
    chk("ar_running", 32'(running), 32'd0);
    chk("ar_flag", 32'(underrun), 32'd0);
    chk("ar_count", 32'(ucnt), 32'd0);
    chk("ar_ready", 32'({a_ready, b_ready}), 32'd0);
    start(16'd3, 1'b0, 1000);
    cyc(4);
    chk("ar_reprime_data", m_data, 32'h0100E000);
    chk("ar_reprime_flag", 32'(underrun), 32'd0);
    chk("ar_reprime_count", 32'(ucnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
